// File: rtl/pe_array_pkg.sv
// pe_array_pkg
// Shared definitions for the PE array controller: default operand width,
// array dimension and pipeline latency, the controller state encoding,
// lane-vector types for the default geometry, the 16-bit counter type and
// the {valid,last} tag carried through the result delay line.
package pe_array_pkg;

  localparam int W_DEF   = 8;
  localparam int N_DEF   = 16;
  localparam int LAT_DEF = 2 * N_DEF - 1;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Lane vectors for the default geometry: N operands and N accumulators.
  typedef logic [N_DEF*W_DEF-1:0]   lane_w_t;
  typedef logic [N_DEF*2*W_DEF-1:0] lane_acc_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // One delay-line stage: a beat is in flight, and whether it closes the job.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/pe_ctrl_delay.sv
// pe_ctrl_delay
// LAT-deep shift register tracking which cycles carry a live activation beat
// through the PE array, so the controller knows when pe_c_out is meaningful.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low clear of every stage
//   in_valid  a beat is being presented to the array this cycle
//   in_last   that beat is the final one of the job
//   out_valid tail stage holds a beat (pe_c_out is valid now)
//   out_last  tail beat is the final one
//   empty     no stage holds a beat
module pe_ctrl_delay
  import pe_array_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic empty
);

  tag_t           tag_w [LAT];
  logic [LAT-1:0] valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      tag_t tag_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) begin
            tag_reg <= '0;
          end else begin
            // last is only meaningful alongside valid
            tag_reg <= '{valid: in_valid, last: in_valid & in_last};
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!rst) begin
            tag_reg <= '0;
          end else begin
            tag_reg <= tag_w[gi-1];
          end
        end
      end

      assign tag_w[gi]     = tag_reg;
      assign valid_vec[gi] = tag_reg.valid;
    end
  endgenerate

  assign out_valid = tag_w[LAT-1].valid;
  assign out_last  = tag_w[LAT-1].last;
  assign empty     = ~|valid_vec;

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
// Sequences a weight-stationary N x N PE array: loads N weight rows, streams
// num_vecs activation vectors, and returns one result vector per activation
// on a backpressure-free output stream.
// Ports:
//   clk, rst                 clock / synchronous active-low reset
//   start, num_vecs          job request (IDLE only) and activation count
//   busy, done               job in progress / one-cycle completion pulse
//   w_valid/w_ready/w_data   weight-row stream (accepted in LOAD_W)
//   x_valid/x_ready/x_data   activation stream (accepted in STREAM)
//   pe_a_in, pe_stationary   weight row and its load strobe to the array
//   pe_b_in, pe_c_in         activation lanes and partial-sum inputs (0)
//   pe_c_out                 array result, valid LAT cycles after pe_b_in
//   y_valid/y_data/y_last    result stream
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int N   = N_DEF,
  parameter int LAT = 2 * N - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vecs,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [N*W-1:0]   w_data,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [N*W-1:0]   x_data,
  output logic [N*W-1:0]   pe_a_in,
  output logic [N*W-1:0]   pe_b_in,
  output logic [N*2*W-1:0] pe_c_in,
  output logic             pe_stationary,
  input  logic [N*2*W-1:0] pe_c_out,
  output logic             y_valid,
  output logic [N*2*W-1:0] y_data,
  output logic             y_last
);

  localparam cnt_t LAST_ROW = cnt_t'(N - 1);

  state_t state_reg, state_next;

  cnt_t num_vecs_reg;
  cnt_t row_cnt_reg;
  cnt_t vec_cnt_reg;

  logic [N*W-1:0]   pe_a_reg;
  logic [N*W-1:0]   pe_b_reg;
  logic             stationary_reg;
  logic             b_valid_reg;
  logic             b_last_reg;
  logic             y_valid_reg;
  logic             y_last_reg;
  logic [N*2*W-1:0] y_data_reg;
  logic             done_reg;

  logic w_hs, x_hs;
  logic last_row, last_vec;
  logic dly_valid, dly_last, dly_empty;
  logic drain_empty;

  assign w_hs     = w_valid & w_ready;
  assign x_hs     = x_valid & x_ready;
  assign last_row = (row_cnt_reg == LAST_ROW);
  assign last_vec = (vec_cnt_reg == num_vecs_reg - cnt_t'(1));

  // A beat registered into pe_b_in this cycle enters the delay line only at
  // the next edge, so it must also hold off the drain exit.
  assign drain_empty = dly_empty & ~b_valid_reg;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD_W;
      end
      LOAD_W: begin
        if (w_hs && last_row) begin
          state_next = (num_vecs_reg == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (x_hs && last_vec) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = 1'b0;
    w_ready = 1'b0;
    x_ready = 1'b0;
    case (state_reg)
      IDLE:    ;
      LOAD_W:  begin busy = 1'b1; w_ready = 1'b1; end
      STREAM:  begin busy = 1'b1; x_ready = 1'b1; end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      num_vecs_reg   <= '0;
      row_cnt_reg    <= '0;
      vec_cnt_reg    <= '0;
      pe_a_reg       <= '0;
      pe_b_reg       <= '0;
      stationary_reg <= 1'b0;
      b_valid_reg    <= 1'b0;
      b_last_reg     <= 1'b0;
      y_valid_reg    <= 1'b0;
      y_last_reg     <= 1'b0;
      y_data_reg     <= '0;
      done_reg       <= 1'b0;
    end else begin
      // done rises on the same edge that returns the FSM to IDLE
      done_reg <= (state_reg == DRAIN) && drain_empty;

      if (state_reg == IDLE && start) begin
        num_vecs_reg <= num_vecs;
        row_cnt_reg  <= '0;
        vec_cnt_reg  <= '0;
      end else begin
        if (w_hs) row_cnt_reg <= row_cnt_reg + cnt_t'(1);
        if (x_hs) vec_cnt_reg <= vec_cnt_reg + cnt_t'(1);
      end

      // Weight row is held on pe_a_in; the strobe marks the load cycle only.
      stationary_reg <= w_hs;
      if (w_hs) pe_a_reg <= w_data;

      // Idle activation cycles present zeros so the array sees bubbles.
      b_valid_reg <= x_hs;
      b_last_reg  <= x_hs & last_vec;
      pe_b_reg    <= x_hs ? x_data : '0;

      y_valid_reg <= dly_valid;
      y_last_reg  <= dly_valid & dly_last;
      if (dly_valid) y_data_reg <= pe_c_out;
    end
  end

  pe_ctrl_delay #(
    .LAT (LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_valid_reg),
    .in_last   (b_last_reg),
    .out_valid (dly_valid),
    .out_last  (dly_last),
    .empty     (dly_empty)
  );

  assign done          = done_reg;
  assign pe_a_in       = pe_a_reg;
  assign pe_b_in       = pe_b_reg;
  assign pe_c_in       = '0;
  assign pe_stationary = stationary_reg;
  assign y_valid       = y_valid_reg;
  assign y_data        = y_data_reg;
  assign y_last        = y_last_reg;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl
// Directed bench for pe_array_ctrl at the default geometry. A behavioural
// PE array returns, LAT cycles after each pe_b_in, a result whose lanes are
// {~b, b}, so every y beat can be predicted from the activation that made it.
module tb_pe_array_ctrl;
  import pe_array_pkg::*;

  localparam int W   = 8;
  localparam int N   = 16;
  localparam int LAT = 2 * N - 1;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      start = 1'b0;
  logic [15:0] num_vecs = '0;
  logic      busy, done;
  logic      w_valid = 1'b0;
  logic      w_ready;
  lane_w_t   w_data = '0;
  logic      x_valid = 1'b0;
  logic      x_ready;
  lane_w_t   x_data = '0;
  lane_w_t   pe_a_in, pe_b_in;
  lane_acc_t pe_c_in, pe_c_out;
  logic      pe_stationary;
  logic      y_valid, y_last;
  lane_acc_t y_data;

  pe_array_ctrl #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .pe_a_in(pe_a_in), .pe_b_in(pe_b_in), .pe_c_in(pe_c_in),
    .pe_stationary(pe_stationary), .pe_c_out(pe_c_out),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic lane_acc_t widen(input lane_w_t b);
    lane_acc_t r;
    for (int i = 0; i < N; i++) r[i*2*W +: 2*W] = {~b[i*W +: W], b[i*W +: W]};
    return r;
  endfunction

  function automatic lane_w_t mkw(input int i);
    lane_w_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = 8'(i + 1 + 16 * j);
    return r;
  endfunction

  function automatic lane_w_t mkx(input int k);
    lane_w_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = 8'(k * 37 + j * 3 + 5);
    return r;
  endfunction

  // Behavioural PE array latency
  lane_w_t pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= pe_b_in;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pe_c_out = widen(pipe[LAT-1]);

  // Output monitor, sampled mid-cycle
  int        stat_cnt = 0;
  int        done_cnt = 0;
  bit        xr_seen  = 1'b0;
  int        yc_q[$];
  lane_acc_t yd_q[$];
  logic      yl_q[$];
  int        hs_q[$];

  always @(negedge clk) begin
    if (pe_stationary === 1'b1) stat_cnt++;
    if (x_ready === 1'b1) xr_seen = 1'b1;
    if (done === 1'b1) begin
      done_cnt++;
      $display("done: cyc=%0d", cyc);
    end
    if (y_valid === 1'b1) begin
      yc_q.push_back(cyc);
      yd_q.push_back(y_data);
      yl_q.push_back(y_last);
      $display("y beat: cyc=%0d last=%0b data=%h", cyc, y_last, y_data);
    end
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    stat_cnt = 0;
    done_cnt = 0;
    xr_seen  = 1'b0;
    yc_q.delete();
    yd_q.delete();
    yl_q.delete();
  endtask

  task automatic load_w(input bit gaps, output int last_hs);
    last_hs = -1;
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1;
      w_data  = mkw(i);
      last_hs = cyc;
      tick();
      chk("w_stat_on", pe_stationary, 1);
      chk("w_pe_a", pe_a_in, mkw(i));
      w_valid = 1'b0;
      if (gaps) begin
        tick();
        chk("w_stat_gap", pe_stationary, 0);
        chk("w_pe_a_hold", pe_a_in, mkw(i));
      end
    end
  endtask

  task automatic stream_x(input int n, input bit gaps, input int base);
    hs_q.delete();
    for (int k = 0; k < n; k++) begin
      chk("x_ready_on", x_ready, 1);
      x_valid = 1'b1;
      x_data  = mkx(base + k);
      hs_q.push_back(cyc);
      tick();
      chk("x_pe_b", pe_b_in, mkx(base + k));
      x_valid = 1'b0;
      if (gaps) begin
        tick();
        chk("x_pe_b_gap", pe_b_in, 0);
      end
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done === 1'b1) begin
        dc = cyc;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    chk("done_seen", dc >= 0, 1);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic check_y(input int n, input int base);
    chk("y_count", yc_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < yc_q.size()) begin
        chk("y_latency", yc_q[k], hs_q[k] + LAT + 2);
        chk("y_data", yd_q[k], widen(mkx(base + k)));
        chk("y_last", yl_q[k], (k == n - 1));
      end
    end
  endtask

  int dc;
  int lh;

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    chk("rst_ctrl", {busy, done, w_ready, x_ready, pe_stationary, y_valid, y_last}, 0);
    chk("rst_pe_a", pe_a_in, 0);
    chk("rst_pe_b", pe_b_in, 0);
    chk("rst_pe_c", pe_c_in, 0);
    chk("rst_y_data", y_data, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // ---- job 1: back-to-back weights, 4 contiguous activations ----
    clear_mon();
    start = 1'b1; num_vecs = 16'd4;
    tick();
    start = 1'b0;
    chk("j1_load_ready", {busy, w_ready, x_ready}, 3'b110);
    load_w(1'b0, lh);
    chk("j1_after_load", {w_ready, x_ready}, 2'b01);
    tick();
    chk("j1_stat_off", pe_stationary, 0);
    chk("j1_pe_a_hold", pe_a_in, mkw(N - 1));
    chk("j1_stat_count", stat_cnt, 16);
    stream_x(4, 1'b0, 0);
    chk("j1_x_ready_off", x_ready, 0);
    chk("j1_busy_drain", busy, 1);
    tick();
    chk("j1_pe_b_zero", pe_b_in, 0);
    chk("j1_pe_c_in", pe_c_in, 0);
    wait_done(dc);
    check_y(4, 0);
    chk("j1_done_cycle", dc, hs_q[3] + LAT + 3);

    // ---- job 2: gapped weights and activations ----
    clear_mon();
    start = 1'b1; num_vecs = 16'd3;
    tick();
    start = 1'b0;
    load_w(1'b1, lh);
    chk("j2_stat_count", stat_cnt, 16);
    stream_x(3, 1'b1, 8);
    wait_done(dc);
    check_y(3, 8);
    chk("j2_done_count", done_cnt, 1);

    // ---- job 3: zero activations ----
    clear_mon();
    start = 1'b1; num_vecs = 16'd0;
    tick();
    start = 1'b0;
    load_w(1'b0, lh);
    wait_done(dc);
    chk("j3_done_cycle", dc, lh + 2);
    chk("j3_x_ready_seen", xr_seen, 0);
    chk("j3_y_count", yc_q.size(), 0);

    // ---- job 4: reset in the middle of streaming ----
    clear_mon();
    start = 1'b1; num_vecs = 16'd4;
    tick();
    start = 1'b0;
    load_w(1'b0, lh);
    stream_x(2, 1'b0, 20);
    rst = 1'b0;
    tick();
    chk("mid_rst_ctrl", {busy, done, w_ready, x_ready, pe_stationary, y_valid, y_last}, 0);
    chk("mid_rst_pe_a", pe_a_in, 0);
    chk("mid_rst_pe_b", pe_b_in, 0);
    chk("mid_rst_y_data", y_data, 0);
    rst = 1'b1;
    clear_mon();
    repeat (60) tick();
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_no_y", yc_q.size(), 0);
    chk("mid_rst_idle", busy, 0);

    clear_mon();
    start = 1'b1; num_vecs = 16'd2;
    tick();
    start = 1'b0;
    load_w(1'b1, lh);
    stream_x(2, 1'b1, 30);
    wait_done(dc);
    check_y(2, 30);

    // ---- job 5: start held while busy must not reload num_vecs ----
    clear_mon();
    start = 1'b1; num_vecs = 16'd2;
    tick();
    num_vecs = 16'd7;
    load_w(1'b0, lh);
    start = 1'b0;
    start = 1'b1;
    stream_x(2, 1'b0, 40);
    start = 1'b0;
    chk("j5_x_ready_off", x_ready, 0);
    wait_done(dc);
    check_y(2, 40);
    chk("j5_done_count", done_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter W, default 8, operand width in bits.
REQ-002 Parameter N, default 16, PE array dimension (rows = columns = lanes).
REQ-003 Parameter LAT, default 2*N-1, cycles from pe_b_in presented to matching pe_c_out valid.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-007 num_vecs  in  16  activation vector count for the job; captured on accepted start.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  one-cycle pulse at job completion.
REQ-010 w_valid / w_ready / w_data  in / out / in  1 / 1 / N*W  weight-row stream.
REQ-011 x_valid / x_ready / x_data  in / out / in  1 / 1 / N*W  activation-vector stream.
REQ-012 pe_a_in / pe_b_in / pe_c_in / pe_stationary  out  N*W / N*W / N*2W / 1  PE array drive.
REQ-013 pe_c_out  in  N*2W  PE array result.
REQ-014 y_valid / y_data / y_last  out  1 / N*2W / 1  result stream; no backpressure.

Function
REQ-015 FSM states: IDLE, LOAD_W, STREAM, DRAIN.
REQ-016 IDLE->LOAD_W on start; latch num_vecs, clear row and vector counters.
REQ-017 LOAD_W: w_ready=1; each w handshake registers w_data into pe_a_in with pe_stationary=1 the next cycle; otherwise pe_stationary=0 and pe_a_in holds.
REQ-018 LOAD_W->STREAM after the N-th weight handshake (row counter N-1 accepted); if num_vecs==0, go to DRAIN instead.
REQ-019 STREAM: x_ready=1; each x handshake registers x_data into pe_b_in the next cycle; a cycle without a handshake drives pe_b_in=0.
REQ-020 pe_c_in SHALL be 0 at all times; pe_stationary SHALL be 0 outside LOAD_W-driven cycles.
REQ-021 Each registered pe_b_in beat pushes a valid bit, plus a last bit for the num_vecs-th beat, into a LAT-deep delay line.
REQ-022 A delay-line tail bit registers pe_c_out into y_data, with y_valid=1 and y_last=tail last bit, one cycle later; total x-handshake-to-y_valid latency is LAT+2 cycles.
REQ-023 STREAM->DRAIN after the num_vecs-th x handshake; x_ready is 0 from that cycle on.
REQ-024 DRAIN->IDLE when the delay line is empty and no y beat is pending; done pulses in the same cycle busy falls.
REQ-025 start outside IDLE SHALL be ignored; w_ready is 0 outside LOAD_W and x_ready is 0 outside STREAM.
REQ-026 Input gaps (valid low) SHALL stall only counters; beats are never duplicated or dropped.
REQ-027 Counters are 16-bit unsigned, with no wrap within a job (max num_vecs=65535).

Reset
REQ-028 rst=0 at any clock edge forces IDLE, clears counters and delay line, and sets every output to 0 (busy, done, w_ready, x_ready, pe_*, y_*) including mid-job; an in-flight job is discarded with no done.

Structure
REQ-029 Package pe_array_pkg holds W, N, LAT defaults, the state enum typedef, and lane-vector typedefs (N*W, N*2W).
REQ-030 One sub-module, pe_ctrl_delay: a parameterised LAT-deep shift register for {valid,last} with synchronous active-low clear.

Verification
REQ-031 Weight load: start, num_vecs=4, 16 back-to-back w beats of 8'h01..8'h10 -> pe_stationary high exactly 16 cycles and pe_a_in matches each beat one cycle later.
REQ-032 Stream: 4 contiguous x beats -> 4 y_valid beats starting LAT+2 cycles after the first x handshake, y_last only on the 4th, and done one cycle after the last y.
REQ-033 Gaps: w_valid toggling 1/0 over 16 rows and x_valid 1/0 -> pe_stationary pulses 16 times total, with exactly num_vecs y beats in order.
REQ-034 num_vecs=0 -> x_ready never asserts, no y_valid, done after weight load and drain.
REQ-035 Mid-job reset: rst=0 during STREAM after 2 of 4 vectors -> next cycle all outputs 0 and IDLE, no done, and a subsequent job completes normally.
REQ-036 start pulsed while busy -> ignored, and num_vecs is unchanged.
